// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake between command logic and the PS/2 host transmitter.
// master: command source; slave: transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-edge device-clocked frame, ACK check.
// Define PS2_TX_RETRY_EN to retry a failed transaction up to two more times.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned START_TIMEOUT  = 1500000,
  parameter int unsigned PACKET_TIMEOUT = 200000
) (
  input  logic         clk100,
  input  logic         rst_n,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe,
  ps2_host_tx_if.slave tx
);

  localparam logic [20:0] InhLast   = 21'(INHIBIT_CYCLES - 1);
  localparam logic [20:0] StartLast = 21'(START_TIMEOUT - 1);
  localparam logic [20:0] PktLast   = 21'(PACKET_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StInhibit, StReq, StData, StAck, StWaitIdle, StFail
  } state_e;

  state_e      state_q, state_d;
  logic [20:0] cnt_q, cnt_d, cnt_inc;
  logic [7:0]  data_q, data_d;
  logic        parity_q, parity_d;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic        dat_oe_q, dat_oe_d;
  logic        clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
  logic        clk_fall;
  logic        last_attempt;

  // Lines idle high, so synchronisers reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_dat_in;
      dat_s2   <= dat_s1;
    end
  end

  assign clk_fall = clk_prev & ~clk_s2;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 21'd1;

`ifdef PS2_TX_RETRY_EN
  logic [1:0] attempt_q;

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      attempt_q <= '0;
    end else if (state_q == StIdle) begin
      attempt_q <= '0;
    end else if (state_q == StFail) begin
      attempt_q <= attempt_q + 2'd1;
    end
  end

  assign last_attempt = (attempt_q == 2'd2);
`else
  assign last_attempt = 1'b1;
`endif

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      data_q   <= '0;
      parity_q <= 1'b0;
      frame_q  <= '1;
      bitcnt_q <= '0;
      dat_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      parity_q <= parity_d;
      frame_q  <= frame_d;
      bitcnt_q <= bitcnt_d;
      dat_oe_q <= dat_oe_d;
    end
  end

  // Data line is only ever pulled while the request/frame is in flight.
  assign ps2_dat_oe = dat_oe_q & ((state_q == StReq) | (state_q == StData));
  assign tx.busy    = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    data_d      = data_q;
    parity_d    = parity_q;
    frame_d     = frame_q;
    bitcnt_d    = bitcnt_q;
    dat_oe_d    = dat_oe_q;
    ps2_clk_oe  = 1'b0;
    tx.tx_ready = 1'b0;
    tx.tx_done  = 1'b0;
    tx.tx_error = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx.tx_ready = 1'b1;
        dat_oe_d    = 1'b0;
        if (tx.tx_valid) begin
          data_d   = tx.tx_data;
          parity_d = ~^tx.tx_data;
          cnt_d    = '0;
          state_d  = StInhibit;
        end
      end
      StInhibit: begin
        ps2_clk_oe = 1'b1;
        dat_oe_d   = 1'b0;
        if (cnt_q >= InhLast) begin
          dat_oe_d = 1'b1;
          frame_d  = {1'b1, parity_q, data_q};
          bitcnt_d = '0;
          cnt_d    = '0;
          state_d  = StReq;
        end
      end
      StReq: begin
        if (clk_fall) begin
          dat_oe_d = ~frame_q[0];
          frame_d  = {1'b1, frame_q[9:1]};
          bitcnt_d = 4'd1;
          cnt_d    = '0;
          state_d  = StData;
        end else if (cnt_q >= StartLast) begin
          state_d = StFail;
        end
      end
      StData: begin
        if (cnt_q >= PktLast) begin
          state_d = StFail;
        end else if (clk_fall) begin
          // Frame LSB is the next symbol; the stop symbol (1) releases the line.
          dat_oe_d = ~frame_q[0];
          frame_d  = {1'b1, frame_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        dat_oe_d = 1'b0;
        if (cnt_q >= PktLast) begin
          state_d = StFail;
        end else if (clk_fall) begin
          state_d = dat_s2 ? StFail : StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (cnt_q >= PktLast) begin
          state_d = StFail;
        end else if (clk_s2 && dat_s2) begin
          tx.tx_done = 1'b1;
          state_d    = StIdle;
        end
      end
      StFail: begin
        dat_oe_d = 1'b0;
        cnt_d    = '0;
        if (last_attempt) begin
          tx.tx_done  = 1'b1;
          tx.tx_error = 1'b1;
          state_d     = StIdle;
        end else begin
          state_d = StInhibit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
